// File: rtl/tcdm_cmd_split.sv
// tcdm_cmd_split
//   Splits one TCDM transfer of arbitrary length into a sequence of
//   commands, none of which crosses a BURST_BYTES-aligned boundary.
//   The commands go to the beat unpacker over a req/gnt handshake, one
//   command at a time.
//
// Ports
//   clk_i, rst_ni             clock (rising edge), async active-low reset
//   trans_{opc,len,add,sid}_i transfer payload (len = bytes - 1)
//   trans_req_i / trans_gnt_o transfer handshake
//   cmd_{opc,len,add,sid}_o   command payload (len = bytes - 1)
//   cmd_last_o                final command of the transfer
//   cmd_req_o / cmd_gnt_i     command handshake
//   busy_o                    a split is in progress
//
// Configuration
//   TCDM_CMD_SPLIT_BYPASS_EN  when defined, the first command is presented
//                             combinationally from the transfer inputs in
//                             IDLE (zero latency). Otherwise the first
//                             command follows acceptance by one cycle.
module tcdm_cmd_split #(
    parameter int unsigned TRANS_SID_WIDTH = 2,
    parameter int unsigned TCDM_ADD_WIDTH  = 12,
    parameter int unsigned TCDM_OPC_WIDTH  = 12,
    parameter int unsigned MCHAN_LEN_WIDTH = 15,
    parameter int unsigned BURST_BYTES     = 128
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [TCDM_OPC_WIDTH-1:0]  trans_opc_i,
    input  logic [MCHAN_LEN_WIDTH-1:0] trans_len_i,
    input  logic [TCDM_ADD_WIDTH-1:0]  trans_add_i,
    input  logic [TRANS_SID_WIDTH-1:0] trans_sid_i,
    input  logic                       trans_req_i,
    output logic                       trans_gnt_o,
    output logic [TCDM_OPC_WIDTH-1:0]  cmd_opc_o,
    output logic [MCHAN_LEN_WIDTH-1:0] cmd_len_o,
    output logic [TCDM_ADD_WIDTH-1:0]  cmd_add_o,
    output logic [TRANS_SID_WIDTH-1:0] cmd_sid_o,
    output logic                       cmd_last_o,
    output logic                       cmd_req_o,
    input  logic                       cmd_gnt_i,
    output logic                       busy_o
);

    localparam int unsigned OFF   = $clog2(BURST_BYTES);
    localparam int unsigned REM_W = MCHAN_LEN_WIDTH + 1;
    // Wide enough for both the remaining byte count and BURST_BYTES itself.
    localparam int unsigned CW    = (REM_W > OFF + 1) ? REM_W : OFF + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [TCDM_ADD_WIDTH-1:0]  cur_add_q, cur_add_d;
    logic [REM_W-1:0]           rem_q, rem_d;
    logic [TCDM_OPC_WIDTH-1:0]  opc_q, opc_d;
    logic [TRANS_SID_WIDTH-1:0] sid_q, sid_d;

    // Source of the command being presented: registers while splitting,
    // the transfer inputs in IDLE when the bypass is built in.
    logic [TCDM_ADD_WIDTH-1:0]  src_add;
    logic [REM_W-1:0]           src_rem;
    logic [TCDM_OPC_WIDTH-1:0]  src_opc;
    logic [TRANS_SID_WIDTH-1:0] src_sid;

    logic [REM_W-1:0]           trans_rem;
    logic [OFF-1:0]             src_off;
    logic [CW-1:0]              room;
    logic [CW-1:0]              rem_ext;
    logic [REM_W-1:0]           chunk;
    logic                       last_c;
    logic [TCDM_ADD_WIDTH-1:0]  nxt_add;
    logic [REM_W-1:0]           nxt_rem;

    // Extra bit keeps all-ones length from overflowing.
    assign trans_rem = REM_W'(trans_len_i) + REM_W'(1);

`ifdef TCDM_CMD_SPLIT_BYPASS_EN
    always_comb begin
        if (state_q == IDLE) begin
            src_add = trans_add_i;
            src_rem = trans_rem;
            src_opc = trans_opc_i;
            src_sid = trans_sid_i;
        end else begin
            src_add = cur_add_q;
            src_rem = rem_q;
            src_opc = opc_q;
            src_sid = sid_q;
        end
    end
`else
    assign src_add = cur_add_q;
    assign src_rem = rem_q;
    assign src_opc = opc_q;
    assign src_sid = sid_q;
`endif

    // Chunk = bytes left before the next burst boundary, capped by rem.
    assign src_off = src_add[OFF-1:0];
    assign room    = CW'(BURST_BYTES) - CW'(src_off);
    assign rem_ext = CW'(src_rem);
    assign chunk   = REM_W'((rem_ext < room) ? rem_ext : room);
    assign last_c  = (chunk == src_rem);
    // Address wraps silently modulo 2^TCDM_ADD_WIDTH.
    assign nxt_add = src_add + TCDM_ADD_WIDTH'(chunk);
    assign nxt_rem = src_rem - chunk;

    // State and context registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cur_add_q <= '0;
            rem_q     <= '0;
            opc_q     <= '0;
            sid_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_add_q <= cur_add_d;
            rem_q     <= rem_d;
            opc_q     <= opc_d;
            sid_q     <= sid_d;
        end
    end

    // Next-state and handshake/payload outputs.
    always_comb begin
        state_d     = state_q;
        cur_add_d   = cur_add_q;
        rem_d       = rem_q;
        opc_d       = opc_q;
        sid_d       = sid_q;
        trans_gnt_o = 1'b0;
        cmd_req_o   = 1'b0;
        cmd_last_o  = 1'b0;
        cmd_add_o   = '0;
        cmd_len_o   = '0;
        cmd_opc_o   = '0;
        cmd_sid_o   = '0;

        unique case (state_q)
            IDLE: begin
`ifdef TCDM_CMD_SPLIT_BYPASS_EN
                trans_gnt_o = cmd_gnt_i;
                cmd_req_o   = trans_req_i;
                cmd_last_o  = last_c;
                cmd_add_o   = src_add;
                cmd_len_o   = MCHAN_LEN_WIDTH'(chunk - REM_W'(1));
                cmd_opc_o   = src_opc;
                cmd_sid_o   = src_sid;
                // Single-chunk transfers complete here without leaving IDLE.
                if (trans_req_i && cmd_gnt_i && !last_c) begin
                    cur_add_d = nxt_add;
                    rem_d     = nxt_rem;
                    opc_d     = trans_opc_i;
                    sid_d     = trans_sid_i;
                    state_d   = SPLIT;
                end
`else
                trans_gnt_o = 1'b1;
                if (trans_req_i) begin
                    cur_add_d = trans_add_i;
                    rem_d     = trans_rem;
                    opc_d     = trans_opc_i;
                    sid_d     = trans_sid_i;
                    state_d   = SPLIT;
                end
`endif
            end
            SPLIT: begin
                cmd_req_o  = 1'b1;
                cmd_last_o = last_c;
                cmd_add_o  = src_add;
                cmd_len_o  = MCHAN_LEN_WIDTH'(chunk - REM_W'(1));
                cmd_opc_o  = src_opc;
                cmd_sid_o  = src_sid;
                if (cmd_gnt_i) begin
                    cur_add_d = nxt_add;
                    rem_d     = nxt_rem;
                    if (last_c) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q == SPLIT);

endmodule

// File: tb/tb_tcdm_cmd_split.sv
// Directed bench for tcdm_cmd_split (default build, BURST_BYTES = 128,
// TCDM_ADD_WIDTH = 12). Inputs change 1 time unit after the rising edge
// and outputs are sampled there, well away from the next edge.
module tb_tcdm_cmd_split;

    logic        clk;
    logic        rst_n;
    logic [11:0] trans_opc;
    logic [14:0] trans_len;
    logic [11:0] trans_add;
    logic [1:0]  trans_sid;
    logic        trans_req;
    logic        trans_gnt;
    logic [11:0] cmd_opc;
    logic [14:0] cmd_len;
    logic [11:0] cmd_add;
    logic [1:0]  cmd_sid;
    logic        cmd_last;
    logic        cmd_req;
    logic        cmd_gnt;
    logic        busy;

    int n_cmp;
    int n_err;

    logic [11:0] exp_opc;
    logic [1:0]  exp_sid;

    tcdm_cmd_split dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .trans_opc_i (trans_opc),
        .trans_len_i (trans_len),
        .trans_add_i (trans_add),
        .trans_sid_i (trans_sid),
        .trans_req_i (trans_req),
        .trans_gnt_o (trans_gnt),
        .cmd_opc_o   (cmd_opc),
        .cmd_len_o   (cmd_len),
        .cmd_add_o   (cmd_add),
        .cmd_sid_o   (cmd_sid),
        .cmd_last_o  (cmd_last),
        .cmd_req_o   (cmd_req),
        .cmd_gnt_i   (cmd_gnt),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a transfer for one cycle; IDLE must grant it immediately.
    task automatic issue(input string tag, input logic [11:0] a, input logic [14:0] l,
                         input logic [11:0] opc, input logic [1:0] sid);
        trans_req = 1'b1;
        trans_add = a;
        trans_len = l;
        trans_opc = opc;
        trans_sid = sid;
        exp_opc   = opc;
        exp_sid   = sid;
        #1;
        chk({tag, ".tgnt"}, 32'(trans_gnt), 32'd1);
        chk({tag, ".idle_req"}, 32'(cmd_req), 32'd0);
        step();
        trans_req = 1'b0;
        trans_add = 12'h0;
        trans_len = 15'h0;
        trans_opc = 12'h0;
        trans_sid = 2'h0;
        #1;
    endtask

    // Check the command currently presented, then let one edge pass.
    task automatic exp_cmd(input string tag, input logic [31:0] a, input logic [31:0] l,
                           input logic lst);
        chk({tag, ".req"},  32'(cmd_req),  32'd1);
        chk({tag, ".add"},  32'(cmd_add),  a);
        chk({tag, ".len"},  32'(cmd_len),  l);
        chk({tag, ".last"}, 32'(cmd_last), 32'(lst));
        chk({tag, ".opc"},  32'(cmd_opc),  32'(exp_opc));
        chk({tag, ".sid"},  32'(cmd_sid),  32'(exp_sid));
        chk({tag, ".busy"}, 32'(busy),     32'd1);
        chk({tag, ".tgnt"}, 32'(trans_gnt), 32'd0);
        step();
    endtask

    task automatic exp_idle(input string tag);
        chk({tag, ".busy"}, 32'(busy),      32'd0);
        chk({tag, ".req"},  32'(cmd_req),   32'd0);
        chk({tag, ".tgnt"}, 32'(trans_gnt), 32'd1);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        trans_req = 1'b0;
        trans_add = 12'h0;
        trans_len = 15'h0;
        trans_opc = 12'h0;
        trans_sid = 2'h0;
        cmd_gnt   = 1'b1;
        exp_opc   = 12'h0;
        exp_sid   = 2'h0;

        // Reset values
        #2;
        chk("rst.req",  32'(cmd_req),   32'd0);
        chk("rst.last", 32'(cmd_last),  32'd0);
        chk("rst.busy", 32'(busy),      32'd0);
        chk("rst.add",  32'(cmd_add),   32'd0);
        chk("rst.len",  32'(cmd_len),   32'd0);
        chk("rst.opc",  32'(cmd_opc),   32'd0);
        chk("rst.tgnt", 32'(trans_gnt), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single command inside one window
        issue("t1", 12'h010, 15'h0007, 12'hA5A, 2'd1);
        exp_cmd("t1.c0", 32'h010, 32'h07, 1'b1);
        exp_idle("t1.end");

        // Crosses one boundary
        issue("t2", 12'h070, 15'h003F, 12'h123, 2'd2);
        exp_cmd("t2.c0", 32'h070, 32'h0F, 1'b0);
        exp_cmd("t2.c1", 32'h080, 32'h2F, 1'b1);
        exp_idle("t2.end");

        // Three full bursts
        issue("t3", 12'h000, 15'h017F, 12'h3C3, 2'd3);
        exp_cmd("t3.c0", 32'h000, 32'h7F, 1'b0);
        exp_cmd("t3.c1", 32'h080, 32'h7F, 1'b0);
        exp_cmd("t3.c2", 32'h100, 32'h7F, 1'b1);
        exp_idle("t3.end");

        // Back-pressure on the second command holds the payload
        issue("t4", 12'h000, 15'h017F, 12'h0F0, 2'd0);
        exp_cmd("t4.c0", 32'h000, 32'h7F, 1'b0);
        cmd_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_cmd($sformatf("t4.hold%0d", i), 32'h080, 32'h7F, 1'b0);
        end
        cmd_gnt = 1'b1;
        #1;
        exp_cmd("t4.c1", 32'h080, 32'h7F, 1'b0);
        exp_cmd("t4.c2", 32'h100, 32'h7F, 1'b1);
        exp_idle("t4.end");

        // Address wraps past the top of the TCDM
        issue("t5", 12'hFC0, 15'h007F, 12'h777, 2'd1);
        exp_cmd("t5.c0", 32'hFC0, 32'h3F, 1'b0);
        exp_cmd("t5.c1", 32'h000, 32'h3F, 1'b1);
        exp_idle("t5.end");

        // Single byte at the last address of a window
        issue("t6", 12'h07F, 15'h0000, 12'h001, 2'd2);
        exp_cmd("t6.c0", 32'h07F, 32'h00, 1'b1);
        exp_idle("t6.end");

        // Reset in the middle of a split
        issue("t7", 12'h000, 15'h017F, 12'h555, 2'd3);
        exp_cmd("t7.c0", 32'h000, 32'h7F, 1'b0);
        chk("t7.pre_req", 32'(cmd_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7.rst_req",  32'(cmd_req),   32'd0);
        chk("t7.rst_busy", 32'(busy),      32'd0);
        chk("t7.rst_add",  32'(cmd_add),   32'd0);
        chk("t7.rst_tgnt", 32'(trans_gnt), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        exp_idle("t7.post");
        issue("t7b", 12'h010, 15'h0007, 12'h9AB, 2'd0);
        exp_cmd("t7b.c0", 32'h010, 32'h07, 1'b1);
        exp_idle("t7b.end");

        // Maximum length: 32768 bytes = 256 bursts, wrapping the 4 KiB space
        issue("t8", 12'h000, 15'h7FFF, 12'hFFF, 2'd3);
        for (int i = 0; i < 256; i++) begin
            exp_cmd($sformatf("t8.c%0d", i), (i * 128) & 32'hFFF, 32'h7F, (i == 255));
        end
        exp_idle("t8.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tcdm_cmd_split.md
# tcdm_cmd_split

Upstream of the TCDM beat unpacker: accepts one TCDM-side transfer of arbitrary length and splits it into a sequence of commands, none of which crosses a BURST_BYTES-aligned address boundary. Each emitted command (opcode, length, start address, stream ID) is handed to the beat unpacker over a req/gnt handshake, one command at a time. This bounds the beat count per command and keeps every command inside one burst window.

## Interface
Parameters:
- TRANS_SID_WIDTH, default 2: stream/transaction ID width.
- TCDM_ADD_WIDTH, default 12: TCDM byte address width.
- TCDM_OPC_WIDTH, default 12: opcode width; passed through unchanged.
- MCHAN_LEN_WIDTH, default 15: length field width. Encoding is byte count minus 1.
- BURST_BYTES, default 128: split boundary in bytes.
  - Power of two.
  - 8 ≤ BURST_BYTES ≤ 2^TCDM_ADD_WIDTH.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- trans_opc_i  in  TCDM_OPC_WIDTH  transfer opcode.
- trans_len_i  in  MCHAN_LEN_WIDTH  transfer length in bytes, minus 1.
- trans_add_i  in  TCDM_ADD_WIDTH  transfer start byte address.
- trans_sid_i  in  TRANS_SID_WIDTH  transfer ID.
- trans_req_i  in  1  transfer valid.
- trans_gnt_o  out  1  transfer accepted.
- cmd_opc_o  out  TCDM_OPC_WIDTH  command opcode.
- cmd_len_o  out  MCHAN_LEN_WIDTH  command length in bytes, minus 1.
- cmd_add_o  out  TCDM_ADD_WIDTH  command start address.
- cmd_sid_o  out  TRANS_SID_WIDTH  command ID.
- cmd_last_o  out  1  final command of the transfer.
- cmd_req_o  out  1  command valid.
- cmd_gnt_i  in  1  command accepted by the unpacker.
- busy_o  out  1  a split is in progress.

## Operation
Terms:
- OFF = log2(BURST_BYTES).
- rem: register holding remaining bytes, MCHAN_LEN_WIDTH+1 bits.
- cur_add: TCDM_ADD_WIDTH-bit current address register.
- opc_q, sid_q: registered opcode and ID.
- chunk = min(rem, BURST_BYTES − cur_add[OFF-1:0]), computed combinationally. Width is MCHAN_LEN_WIDTH+1.

FSM states:
- IDLE:
  - trans_gnt_o = 1.
  - On trans_req_i: latch opc_q = trans_opc_i, sid_q = trans_sid_i, cur_add = trans_add_i, rem = trans_len_i + 1 (no overflow, thanks to the extra bit).
  - Go to SPLIT.
- SPLIT:
  - trans_gnt_o = 0 and cmd_req_o = 1.
  - cmd_add_o = cur_add.
  - cmd_len_o = chunk − 1, truncated to MCHAN_LEN_WIDTH.
  - cmd_last_o = (chunk == rem).
  - cmd_opc_o = opc_q, cmd_sid_o = sid_q.
  - On cmd_gnt_i: cur_add += chunk (wraps modulo 2^TCDM_ADD_WIDTH) and rem −= chunk.
  - If cmd_last_o was set, go to IDLE.

Rules:
- Command payload is stable while cmd_req_o = 1 and cmd_gnt_i = 0.
- cmd_req_o never drops without a grant.
- busy_o = (state == SPLIT).
- Address wrap is silent: no error, no extra command.
- A single-byte transfer (trans_len_i = 0) yields one command with len 0 and last = 1.
- Maximum length: trans_len_i = all-ones → rem = 2^MCHAN_LEN_WIDTH, handled with no truncation of rem.
- Asserting rst_ni low at any time, including mid-split, immediately forces:
  - state IDLE;
  - all registers to 0;
  - cmd_req_o = 0, busy_o = 0.
- A partially issued transfer is dropped on reset.

## Timing
- Reset values:
  - cmd_req_o 0, cmd_last_o 0, busy_o 0.
  - cmd_* payload 0.
  - trans_gnt_o 1 (state IDLE).
- Transfer handshake completes in the same cycle trans_req_i is seen in IDLE.
- First command: cmd_req_o rises the cycle after acceptance (latency 1).
- Throughput: one command per cycle while cmd_gnt_i = 1.
- Next transfer: accepted the cycle after the last command's grant, so there is a 1-cycle IDLE gap between transfers.

## Configuration
Macro TCDM_CMD_SPLIT_BYPASS_EN.

Defined:
- In IDLE, the first command is presented combinationally from the inputs:
  - cmd_req_o = trans_req_i, cmd_add_o = trans_add_i;
  - chunk is computed from trans_add_i and trans_len_i + 1;
  - cmd_opc_o, cmd_sid_o come from the inputs.
- trans_gnt_o = cmd_gnt_i.
- On that grant:
  - if the first command is last, stay in IDLE;
  - otherwise latch the remainder (cur_add + chunk, rem − chunk, opc, sid) and go to SPLIT.
- Zero-latency first command.
- Back-to-back single-chunk transfers issue every cycle.

Not defined: behaviour exactly as in Operation and Timing (latency 1).

## Test plan
BURST_BYTES = 128, TCDM_ADD_WIDTH = 12, cmd_gnt_i = 1 unless stated.
- add 0x010, len 7 → one command: add 0x010, len 7, last = 1; busy_o high for 1 cycle.
- add 0x070, len 0x3F → two commands:
  - add 0x070, len 0x0F, last 0;
  - add 0x080, len 0x2F, last 1.
- add 0x000, len 0x17F → three commands at 0x000, 0x080, 0x100, each len 0x7F; last only on the third.
- Case above with cmd_gnt_i low for 3 cycles on the second command → cmd_add_o holds 0x080 and cmd_len_o holds 0x7F throughout; trans_gnt_o stays 0.
- add 0xFC0, len 0x7F → two commands:
  - add 0xFC0, len 0x3F;
  - add 0x000, len 0x3F, last 1.
- Reset asserted during the second command of the 0x17F case → cmd_req_o = 0 and busy_o = 0 immediately; after release trans_gnt_o = 1; a new len 7 transfer issues normally.
- Bypass variant, TCDM_CMD_SPLIT_BYPASS_EN defined: first command appears in the trans_req_i cycle.
